// File: rtl/spi_pkg.sv
// Shared helpers and FSM state encoding for the multi-target SPI master.
package spi_pkg;

   function automatic int spi_clog2(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < value) w = i + 1;
      return w;
   endfunction

   // Chip-select index width; a single target still needs one bit.
   function automatic int spi_tgt_w(input int num_cs);
      return (num_cs > 1) ? spi_clog2(num_cs) : 1;
   endfunction

   typedef logic [2:0] spi_state_t;

   localparam spi_state_t ST_IDLE  = 3'd0;
   localparam spi_state_t ST_LOW   = 3'd1;
   localparam spi_state_t ST_HIGH  = 3'd2;
   localparam spi_state_t ST_HOLD  = 3'd3;
   localparam spi_state_t ST_LATCH = 3'd4;
   localparam spi_state_t ST_GAP   = 3'd5;

endpackage

// File: rtl/spi_multi_master_if.sv
// Request handshake and serial pin bundle for spi_multi_master.
interface spi_multi_master_if import spi_pkg::*; #(
   parameter int MAX_BITS = 32,
   parameter int NUM_CS   = 4
) ();
   localparam int LEN_W = spi_clog2(MAX_BITS + 1);
   localparam int TGT_W = spi_tgt_w(NUM_CS);

   logic                req_valid;
   logic                req_ready;
   logic [MAX_BITS-1:0] req_data;
   logic [LEN_W-1:0]    req_len;
   logic [TGT_W-1:0]    req_target;
   logic                req_latch;
   logic                busy;
   logic                done;
   logic                spi_sclk;
   logic                spi_dat;
   logic [NUM_CS-1:0]   spi_cs_n;
   logic                latch_clk;

   modport master (
      input  req_valid, req_data, req_len, req_target, req_latch,
      output req_ready, busy, done, spi_sclk, spi_dat, spi_cs_n, latch_clk
   );

   modport slave (
      output req_valid, req_data, req_len, req_target, req_latch,
      input  req_ready, busy, done, spi_sclk, spi_dat, spi_cs_n, latch_clk
   );
endinterface

// File: rtl/spi_req_fifo.sv
// Show-ahead request FIFO: rdata always presents the oldest entry.
module spi_req_fifo import spi_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk25,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int PTR_W = spi_clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W:0]   wptr;
   logic [PTR_W:0]   rptr;

   always_ff @(posedge clk25 or posedge reset) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push && !full)
            wptr <= wptr + 1'b1;
         if (pop && !empty)
            rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk25) begin
      if (push && !full)
         mem[wptr[PTR_W-1:0]] <= wdata;
   end

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign rdata = mem[rptr[PTR_W-1:0]];
   assign empty = (wptr == rptr);
   assign full  = (wptr[PTR_W] != rptr[PTR_W]) &&
                  (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
endmodule

// File: rtl/spi_multi_master.sv
// Queued mode-0 SPI master driving several write-only targets on one SCLK/MOSI pair,
// with per-frame length, chip select and optional latch strobe.
module spi_multi_master import spi_pkg::*; #(
   parameter int MAX_BITS   = 32,
   parameter int NUM_CS     = 4,
   parameter int CLK_DIV    = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk25,
   input  logic               reset,
   spi_multi_master_if.master bus
);
   localparam int LEN_W = spi_clog2(MAX_BITS + 1);
   localparam int TGT_W = spi_tgt_w(NUM_CS);
   localparam int CNT_W = spi_clog2(CLK_DIV + 1);

   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(CLK_DIV - 1);
   localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_BITS);
   localparam logic [TGT_W:0]   TGT_LIMIT = (TGT_W + 1)'(NUM_CS);

   typedef struct packed {
      logic [MAX_BITS-1:0] data;
      logic [LEN_W-1:0]    len;
      logic [TGT_W-1:0]    target;
      logic                latch;
   } req_t;

   req_t                wr_req;
   req_t                rd_req;
   logic                fifo_full;
   logic                fifo_empty;
   logic                pop;
   logic                req_ok;
   logic [LEN_W-1:0]    len_sat;
   logic                phase_end;
   logic                cs_active;
   logic [NUM_CS-1:0]   cs_n_c;

   spi_state_t          state;
   logic [CNT_W-1:0]    cnt;
   logic [LEN_W-1:0]    bitcnt;
   logic [MAX_BITS-1:0] shreg;
   logic [TGT_W-1:0]    tgt;
   logic                latch_en;

   assign wr_req.data   = bus.req_data;
   assign wr_req.len    = bus.req_len;
   assign wr_req.target = bus.req_target;
   assign wr_req.latch  = bus.req_latch;

   spi_req_fifo #(
      .WIDTH ($bits(req_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk25 (clk25),
      .reset (reset),
      .push  (bus.req_valid),
      .wdata (wr_req),
      .pop   (pop),
      .rdata (rd_req),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Pop-time screening: empty frames and unknown targets are dropped silently.
   assign pop       = (state == ST_IDLE) && !fifo_empty;
   assign len_sat   = (rd_req.len > LEN_MAX) ? LEN_MAX : rd_req.len;
   assign req_ok    = (rd_req.len != '0) && ({1'b0, rd_req.target} < TGT_LIMIT);
   assign phase_end = (cnt == '0);

   always_ff @(posedge clk25 or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         bitcnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop && req_ok) begin
                  state  <= ST_LOW;
                  cnt    <= CNT_LOAD;
                  bitcnt <= len_sat;
               end
            end
            ST_LOW: begin
               if (phase_end) begin
                  state <= ST_HIGH;
                  cnt   <= CNT_LOAD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_HIGH: begin
               if (phase_end) begin
                  bitcnt <= bitcnt - 1'b1;
                  cnt    <= CNT_LOAD;
                  state  <= (bitcnt == LEN_W'(1)) ? ST_HOLD : ST_LOW;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_HOLD: begin
               if (phase_end) begin
                  cnt   <= CNT_LOAD;
                  state <= latch_en ? ST_LATCH : ST_GAP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_LATCH: begin
               if (phase_end) begin
                  cnt   <= CNT_LOAD;
                  state <= ST_GAP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_GAP: begin
               if (phase_end)
                  state <= ST_IDLE;
               else
                  cnt <= cnt - 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Payload is left-aligned so the frame's first bit always sits at the MSB.
   always_ff @(posedge clk25) begin
      if (pop && req_ok) begin
         shreg    <= rd_req.data << (LEN_MAX - len_sat);
         tgt      <= rd_req.target;
         latch_en <= rd_req.latch;
      end else if ((state == ST_HIGH) && phase_end) begin
         shreg <= shreg << 1;
      end
   end

   assign cs_active = (state == ST_LOW) || (state == ST_HIGH) || (state == ST_HOLD);

   always_comb begin
      cs_n_c = '1;
      for (int i = 0; i < NUM_CS; i++)
         cs_n_c[i] = !(cs_active && (tgt == TGT_W'(i)));
   end

   // Pins decode straight from state so an async reset idles them in the same cycle.
   assign bus.spi_cs_n  = cs_n_c;
   assign bus.spi_sclk  = (state == ST_HIGH);
   assign bus.spi_dat   = ((state == ST_LOW) || (state == ST_HIGH)) && shreg[MAX_BITS-1];
   assign bus.latch_clk = (state == ST_LATCH);
   assign bus.done      = (state == ST_GAP) && (cnt == CNT_LOAD);
   assign bus.busy      = !fifo_empty || (state != ST_IDLE);
   assign bus.req_ready = !fifo_full;
endmodule

// File: tb/tb_spi_multi_master.sv
// Randomised bench for spi_multi_master: a pin monitor rebuilds each frame and
// compares it with frames predicted from the request stream.
module tb_spi_multi_master;
   localparam int MB  = 32;
   localparam int NCS = 3;
   localparam int CD  = 2;
   localparam int FD  = 4;

   logic clk25 = 1'b0;
   logic reset = 1'b1;
   always #5 clk25 = ~clk25;

   spi_multi_master_if #(.MAX_BITS(MB), .NUM_CS(NCS)) bus ();

   spi_multi_master #(
      .MAX_BITS(MB), .NUM_CS(NCS), .CLK_DIV(CD), .FIFO_DEPTH(FD)
   ) dut (
      .clk25 (clk25),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int          tgt;
      int          len;
      longint      val;
      bit          latch;
      int          gap;
   } frame_t;

   frame_t exp_q[$];
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input longint got, input longint want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: observed %0d, expected %0d", tag, got, want);
      end
   endtask

   // Pin monitor state
   bit     in_frame = 0;
   bit     await_done = 0;
   int     cur_tgt, low_cnt, edges, hi_cnt = 0, latch_cnt = 0, exp_latch = 0;
   int     dat_age = 0, n_done = 0;
   longint val;
   logic   prev_sclk = 0, prev_dat = 0;
   int     v_multi_cs = 0, v_idle = 0, v_dat = 0, v_done = 0;

   always @(negedge clk25) begin : mon
      int nlow, idx;
      frame_t f;
      if (reset) begin
         in_frame = 0; await_done = 0; hi_cnt = 0;
         prev_sclk = 0; prev_dat = 0; dat_age = 0;
      end else begin
         nlow = 0; idx = 0;
         for (int i = 0; i < NCS; i++)
            if (!bus.spi_cs_n[i]) begin nlow++; idx = i; end
         if (nlow > 1) v_multi_cs++;
         if (bus.spi_dat != prev_dat) dat_age = 1; else dat_age++;
         if (nlow != 0) begin
            if (!in_frame) begin
               in_frame = 1; cur_tgt = idx; low_cnt = 0; edges = 0; val = 0;
               if (exp_q.size() > 0 && exp_q[0].gap >= 0)
                  check("frame_gap", hi_cnt, exp_q[0].gap);
            end
            low_cnt++;
            if (bus.spi_sclk && !prev_sclk) begin
               edges++;
               val = (val << 1) | longint'(bus.spi_dat);
               if (dat_age <= CD) v_dat++;
            end
            if (bus.spi_sclk && prev_sclk && bus.spi_dat != prev_dat) v_dat++;
            if (bus.latch_clk) v_idle++;
         end else begin
            if (bus.spi_sclk || bus.spi_dat) v_idle++;
            if (in_frame) begin
               in_frame = 0; hi_cnt = 0;
               if (await_done) v_done++;
               if (exp_q.size() == 0) begin
                  check("unexpected_frame", 1, 0);
               end else begin
                  f = exp_q.pop_front();
                  check("target", cur_tgt, f.tgt);
                  check("sclk_edges", edges, f.len);
                  check("data", val, f.val);
                  check("cs_low_cycles", low_cnt, (2 * f.len + 1) * CD);
                  exp_latch = f.latch ? CD : 0;
                  latch_cnt = 0;
                  await_done = 1;
               end
            end
            hi_cnt++;
         end
         if (bus.latch_clk) latch_cnt++;
         if (bus.done) begin
            if (await_done) begin
               check("latch_cycles", latch_cnt, exp_latch);
               await_done = 0;
               n_done++;
            end else begin
               v_done++;
            end
         end
         prev_sclk = bus.spi_sclk;
         prev_dat  = bus.spi_dat;
      end
   end

   // Reference model: what should appear on the pins for one accepted request.
   task automatic model_add(input logic [31:0] data, input int len, input int tgt,
                            input bit latch, input int gap);
      frame_t f;
      int l;
      if (len == 0 || tgt >= NCS) return;
      l = (len > MB) ? MB : len;
      f.tgt = tgt; f.len = l; f.latch = latch; f.gap = gap;
      f.val = longint'(data) & ((64'd1 << l) - 1);
      exp_q.push_back(f);
   endtask

   task automatic push_req(input logic [31:0] data, input int len, input int tgt,
                           input bit latch, input int gap, output time acc_t);
      int waited;
      waited = 0;
      @(negedge clk25);
      bus.req_valid = 1'b1; bus.req_data = data; bus.req_len = 6'(len);
      bus.req_target = 2'(tgt); bus.req_latch = latch;
      while (!bus.req_ready && waited < 3000) begin @(negedge clk25); waited++; end
      if (!bus.req_ready) begin
         check("push_timeout", 0, 1);
         bus.req_valid = 1'b0;
         acc_t = 0;
         return;
      end
      acc_t = $time;
      @(posedge clk25); #1;
      bus.req_valid = 1'b0;
      model_add(data, len, tgt, latch, gap);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while ((bus.busy || exp_q.size() != 0 || await_done || in_frame) && n < 20000) begin
         @(negedge clk25); #1; n++;
      end
      check({tag, "_idle"}, (n < 20000) ? 1 : 0, 1);
      repeat (3) @(negedge clk25);
   endtask

   task automatic check_idle_pins(input string tag);
      check({tag, "_cs_n"}, bus.spi_cs_n, 3'b111);
      check({tag, "_sclk"}, bus.spi_sclk, 0);
      check({tag, "_dat"}, bus.spi_dat, 0);
      check({tag, "_latch"}, bus.latch_clk, 0);
      check({tag, "_done"}, bus.done, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_ready"}, bus.req_ready, 1);
   endtask

   initial begin
      time t0, t, tl;
      int d0, n;
      bus.req_valid = 0; bus.req_data = '0; bus.req_len = '0;
      bus.req_target = '0; bus.req_latch = 0;
      repeat (3) @(negedge clk25);
      check_idle_pins("reset");
      reset = 1'b0;
      repeat (2) @(negedge clk25);

      // Single 8-bit frame to target 1
      d0 = n_done;
      push_req(32'hA5, 8, 1, 0, -1, t);
      wait_idle("t1");
      check("t1_done", n_done - d0, 1);
      check("t1_busy", bus.busy, 0);

      // 16-bit frame with latch strobe
      d0 = n_done;
      push_req(32'h0F3C, 16, 0, 1, -1, t);
      wait_idle("t2");
      check("t2_done", n_done - d0, 1);

      // Five back-to-back pushes into a depth-4 queue
      d0 = n_done;
      push_req($urandom, $urandom_range(4, 12), $urandom_range(0, NCS - 1), 0, -1, t0);
      for (int i = 1; i < 5; i++)
         push_req($urandom, $urandom_range(4, 12), $urandom_range(0, NCS - 1), 0, 3, tl);
      check("b2b_accept_cycles", (tl - t0) / 10, 4);
      check("b2b_ready_full", bus.req_ready, 0);
      wait_idle("t3");
      check("t3_done", n_done - d0, 5);

      // Discarded requests followed by a good one
      d0 = n_done;
      push_req(32'hFF, 0, 0, 0, -1, t);
      push_req(32'hFF, 8, NCS, 1, -1, t);
      push_req(32'h3C, 6, 2, 0, -1, t);
      wait_idle("t4");
      check("t4_done", n_done - d0, 1);

      // Over-length request saturates to MAX_BITS
      push_req(32'hDEADBEEF, 40, 2, 0, -1, t);
      wait_idle("t5");

      // Reset in the middle of a frame with more requests queued
      push_req(32'h12345, 20, 1, 0, -1, t);
      push_req(32'h1, 4, 0, 0, -1, t);
      push_req(32'h2, 4, 2, 1, -1, t);
      n = 0;
      while (!(in_frame && edges == 5) && n < 2000) begin @(negedge clk25); #1; n++; end
      check("t6_reach_bit5", (n < 2000) ? 1 : 0, 1);
      d0 = n_done;
      #2 reset = 1'b1;
      #1 check_idle_pins("midreset");
      exp_q.delete();
      repeat (2) @(negedge clk25);
      reset = 1'b0;
      repeat (5) @(negedge clk25);
      check("t6_flushed", bus.busy, 0);
      check("t6_no_done", n_done - d0, 0);
      push_req(32'h5A, 8, 0, 1, -1, t);
      wait_idle("t6");
      check("t6_post_done", n_done - d0, 1);

      // Random traffic, including invalid lengths and targets
      for (int i = 0; i < 25; i++) begin
         push_req($urandom, $urandom_range(0, 40), $urandom_range(0, NCS),
                  1'($urandom_range(0, 1)), -1, t);
         repeat ($urandom_range(0, 30)) @(negedge clk25);
      end
      wait_idle("rand");

      check("one_cs_low", v_multi_cs, 0);
      check("idle_pin_activity", v_idle, 0);
      check("dat_stability", v_dat, 0);
      check("done_pulses", v_done, 0);
      check("model_queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
      $fatal(1, "watchdog");
   end
endmodule
